// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt sequencer feeding one core interrupt line.
// Define IRQ_EDGE_EN for edge-captured sources; the default build is level mode.
module irq_arbiter #(
   parameter int NSRC        = 4,
   parameter int IDW         = 2,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] src,
   input  logic            cfg_we,
   input  logic [1:0]      cfg_addr,
   input  logic [NSRC-1:0] cfg_wdata,
   input  logic            irq_ack,
   input  logic            irq_done,
   output logic            irq,
   output logic [IDW-1:0]  irq_id,
   output logic [NSRC-1:0] pending,
   output logic            busy,
   output logic            err
);

   localparam int TW = $clog2(ACK_TIMEOUT);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t          state, state_d;
   logic [TW-1:0]   timer;
   logic [NSRC-1:0] enable, src_q, pend_q;
   logic [NSRC-1:0] req_vec, set_vec, clr_vec;
   logic [IDW-1:0]  win;
   logic            wr_en, wr_set, wr_clr, wr_err;
   logic            take_ack, timeout;

   assign wr_en  = cfg_we && (cfg_addr == 2'd0);
   assign wr_set = cfg_we && (cfg_addr == 2'd1);
   assign wr_clr = cfg_we && (cfg_addr == 2'd2);
   assign wr_err = cfg_we && (cfg_addr == 2'd3);

   assign take_ack = (state == REQ) && irq_ack;
   assign timeout  = (state == REQ) && !irq_ack && (timer == TW'(ACK_TIMEOUT - 1));

`ifdef IRQ_EDGE_EN
   // pend_q holds everything; a rising edge is captured as a sticky bit
   assign set_vec = (wr_set ? cfg_wdata : '0) | (src & ~src_q);
   assign pending = pend_q;
`else
   // pend_q is the software part only; the sampled level is ORed back in
   assign set_vec = wr_set ? cfg_wdata : '0;
   assign pending = pend_q | src_q;
`endif

   assign clr_vec = (wr_clr ? cfg_wdata : '0) |
                    (take_ack ? (NSRC'(1) << irq_id) : '0);
   assign req_vec = pending & enable;
   assign busy    = (state != IDLE);

   // lowest index wins: scan downward so the last hit is the smallest
   always_comb begin
      win = '0;
      for (int i = NSRC - 1; i >= 0; i--)
         if (req_vec[i]) win = IDW'(i);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (|req_vec) state_d = REQ;
         REQ:     if (irq_ack) state_d = SERVICE;
                  else if (timeout) state_d = IDLE;
         SERVICE: if (irq_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         irq    <= 1'b0;
         irq_id <= '0;
         timer  <= '0;
         enable <= '0;
         src_q  <= '0;
         pend_q <= '0;
         err    <= 1'b0;
      end else begin
         irq    <= (state_d == REQ);
         src_q  <= src;
         pend_q <= (pend_q & ~clr_vec) | set_vec;
         if (wr_en) enable <= cfg_wdata;
         if (state == IDLE && state_d == REQ) begin
            irq_id <= win;
            timer  <= '0;
         end else if (state == REQ && timer != TW'(ACK_TIMEOUT - 1)) begin
            timer  <= timer + 1'b1;
         end
         if (timeout)     err <= 1'b1;
         else if (wr_err) err <= 1'b0;
      end
   end

endmodule
